sifive_datatap_trace_buffer: RTL and testbench

- Consumes the six raw core/CSR tap signals of the E21 data-tap stage: 1-bit retire valid, 32-bit CSR value, and four 1-bit status flags.
- Timestamps qualifying events, packs them into fixed-width trace records and buffers them in a FIFO.
- Presents records on a valid/ready stream to the riscv-dv trace monitor or bridge.
- Counts and flags records dropped because the FIFO was full.

---
 rtl/sifive_datatap_trace_pkg.sv | 20 ++
 rtl/sifive_datatap_trace_fifo.sv | 63 ++++++
 rtl/sifive_datatap_trace_buffer.sv | 97 +++++++++
 tb/tb_sifive_datatap_trace_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sifive_datatap_trace_pkg.sv
// Shared types and constants for the E21 data-tap trace buffer.
// trace_rec_t describes the record layout at the default timestamp width.
package sifive_datatap_trace_pkg;

    localparam int VALUE_W  = 32;
    localparam int FLAGS_W  = 4;
    localparam int DEF_TS_W = 16;
    localparam int DROP_W   = 16;

    // Bit positions inside tap_flags: {exception, interrupt, csr_flag_a, csr_flag_b}
    localparam int FLAG_EXC = 3;
    localparam int FLAG_IRQ = 2;

    typedef struct packed {
        logic [DEF_TS_W-1:0] ts;
        logic [FLAGS_W-1:0]  flags;
        logic [VALUE_W-1:0]  value;
    } trace_rec_t;

endpackage

// File: rtl/sifive_datatap_trace_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, occupancy and synchronous clear.
// Read data is masked to zero while empty so the output is defined from reset.
module sifive_datatap_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 52
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
    assign do_pop  = pop_i & ~empty_o & ~clear_i;
    assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sifive_datatap_trace_buffer.sv
// Data-tap trace buffer: qualifies tap events, stamps them with a saturating
// cycle delta, buffers records in a FIFO and tracks records lost to a full FIFO.
module sifive_datatap_trace_buffer
    import sifive_datatap_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    localparam int REC_W = VALUE_W + FLAGS_W + TS_W,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                tap_valid,
    input  logic [VALUE_W-1:0]  tap_value,
    input  logic [FLAGS_W-1:0]  tap_flags,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [REC_W-1:0]    rec_data,
    output logic [LVL_W-1:0]    fill_level,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_count,
    input  logic                clear
);

    localparam logic [TS_W-1:0]   TS_MAX   = '1;
    localparam logic [TS_W-1:0]   TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              capture, pop_fire, accept, drop;
    logic              fifo_full, fifo_empty;
    logic [REC_W-1:0]  rec_word;

    // Exceptions and interrupts are traced even when no instruction retires.
    assign capture  = enable & (tap_valid | tap_flags[FLAG_EXC] | tap_flags[FLAG_IRQ]);
    assign pop_fire = rec_valid & rec_ready;
    assign accept   = capture & (~fifo_full | pop_fire) & ~clear;
    assign drop     = capture & fifo_full & ~pop_fire & ~clear;
    assign rec_word = {ts_cnt_q, tap_flags, tap_value};

    always_comb begin
        ts_cnt_d   = ts_cnt_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            ts_cnt_d   = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // Drops leave the counter running so the next kept delta spans them.
            if (accept)                  ts_cnt_d = TS_ONE;
            else if (ts_cnt_q != TS_MAX) ts_cnt_d = ts_cnt_q + TS_ONE;
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_cnt_q   <= ts_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sifive_datatap_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (clear),
        .push_i  (accept),
        .data_i  (rec_word),
        .pop_i   (rec_ready),
        .data_o  (rec_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fill_level)
    );

    assign rec_valid  = ~fifo_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sifive_datatap_trace_buffer.sv
// Directed bench for sifive_datatap_trace_buffer: a vector table for single-cycle
// behaviour, then hand-written sequences for overflow, saturation, clear and reset.
module tb_sifive_datatap_trace_buffer;
    import sifive_datatap_trace_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable, tap_valid, rec_ready, clear;
    logic [31:0] tap_value;
    logic [3:0]  tap_flags;
    logic        rec_valid, overflow;
    logic [51:0] rec_data;
    logic [3:0]  fill_level;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [51:0] exp_q[$];

    typedef struct {
        logic        en, tv;
        logic [31:0] val;
        logic [3:0]  fl;
        logic        rdy, clr;
        logic        exp_v;
        logic [51:0] exp_d;
        logic [3:0]  exp_f;
        logic        exp_o;
        logic [15:0] exp_dc;
    } vec_t;

    vec_t vecs[14];

    sifive_datatap_trace_buffer #(.DEPTH(8), .TS_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .tap_valid  (tap_valid),
        .tap_value  (tap_value),
        .tap_flags  (tap_flags),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .fill_level (fill_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear      (clear)
    );

    always #5 clock = ~clock;

    function automatic logic [51:0] mkrec(input logic [15:0] ts, input logic [3:0] fl,
                                          input logic [31:0] val);
        trace_rec_t r;
        r.ts    = ts;
        r.flags = fl;
        r.value = val;
        return r;
    endfunction

    function automatic vec_t mkv(input logic en, tv, input logic [31:0] val, input logic [3:0] fl,
                                 input logic rdy, clr, input logic ev, input logic [51:0] ed,
                                 input logic [3:0] ef, input logic eo, input logic [15:0] edc);
        vec_t v;
        v.en = en; v.tv = tv; v.val = val; v.fl = fl; v.rdy = rdy; v.clr = clr;
        v.exp_v = ev; v.exp_d = ed; v.exp_f = ef; v.exp_o = eo; v.exp_dc = edc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_out(input string name, input logic ev, input logic [51:0] ed,
                             input logic [3:0] ef, input logic eo, input logic [15:0] edc);
        chk({name, ".rec_valid"},  64'(rec_valid),  64'(ev));
        chk({name, ".rec_data"},   64'(rec_data),   64'(ed));
        chk({name, ".fill_level"}, 64'(fill_level), 64'(ef));
        chk({name, ".overflow"},   64'(overflow),   64'(eo));
        chk({name, ".drop_count"}, 64'(drop_count), 64'(edc));
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic drive(input logic en, tv, input logic [31:0] val, input logic [3:0] fl,
                         input logic rdy, clr);
        enable = en; tap_valid = tv; tap_value = val; tap_flags = fl;
        rec_ready = rdy; clear = clr;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 4'h0, rdy, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 0; tap_valid = 0; tap_value = 0; tap_flags = 0; rec_ready = 0; clear = 0;

        // Cycles 0-4 idle, tap at cycle 5, then flag-only and enable-gated events.
        for (int i = 0; i < 5; i++)
            vecs[i] = mkv(1, 0, 32'h0, 4'h0, 0, 0, 0, 52'h0, 4'd0, 0, 16'd0);
        vecs[5]  = mkv(1, 1, 32'hDEADBEEF, 4'h0, 0, 0, 1, mkrec(16'd5, 4'h0, 32'hDEADBEEF), 4'd1, 0, 16'd0);
        vecs[6]  = mkv(1, 0, 32'h0, 4'h0, 1, 0, 0, 52'h0, 4'd0, 0, 16'd0);
        vecs[7]  = mkv(1, 0, 32'h12345678, 4'h8, 0, 0, 1, mkrec(16'd2, 4'h8, 32'h12345678), 4'd1, 0, 16'd0);
        vecs[8]  = mkv(0, 0, 32'h12345678, 4'h8, 1, 0, 0, 52'h0, 4'd0, 0, 16'd0);
        vecs[9]  = mkv(1, 0, 32'hCAFE0001, 4'h4, 0, 0, 1, mkrec(16'd2, 4'h4, 32'hCAFE0001), 4'd1, 0, 16'd0);
        vecs[10] = mkv(1, 0, 32'h0, 4'h0, 1, 0, 0, 52'h0, 4'd0, 0, 16'd0);
        vecs[11] = mkv(0, 1, 32'h11111111, 4'h0, 0, 0, 0, 52'h0, 4'd0, 0, 16'd0);
        vecs[12] = mkv(1, 1, 32'hA5A5A5A5, 4'h3, 0, 0, 1, mkrec(16'd3, 4'h3, 32'hA5A5A5A5), 4'd1, 0, 16'd0);
        vecs[13] = mkv(1, 0, 32'h0, 4'h0, 1, 0, 0, 52'h0, 4'd0, 0, 16'd0);

        repeat (3) @(negedge clock);
        check_out("reset_held", 0, 52'h0, 4'd0, 0, 16'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, vecs[i].tv, vecs[i].val, vecs[i].fl, vecs[i].rdy, vecs[i].clr);
            check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_f,
                      vecs[i].exp_o, vecs[i].exp_dc);
        end

        // Ten captures into an 8-deep FIFO with the consumer stalled; ts starts at 2.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 32'h1000 + i, 4'h0, 0, 0);
            if (i < 8) exp_q.push_back(mkrec((i == 0) ? 16'd2 : 16'd1, 4'h0, 32'h1000 + i));
        end
        check_out("overflow_fill", 1, exp_q[0], 4'd8, 1, 16'd2);

        // Capture and pop together while full: accepted, delta spans the two drops.
        void'(exp_q.pop_front());
        exp_q.push_back(mkrec(16'd3, 4'h0, 32'h2000));
        drive(1, 1, 32'h2000, 4'h0, 1, 0);
        check_out("full_push_pop", 1, exp_q[0], 4'd8, 1, 16'd2);

        idle(2, 0);
        chk("stall_stable", 64'(rec_data), 64'(exp_q[0]));
        chk("stall_valid", 64'(rec_valid), 64'd1);

        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 64'(rec_data), 64'(exp_q.pop_front()));
            idle(1, 1);
        end
        check_out("drained", 0, 52'h0, 4'd0, 1, 16'd2);

        // Long idle saturates the delta, then the counter restarts from the capture.
        idle(70000, 0);
        drive(1, 1, 32'h5A5A0000, 4'h0, 0, 0);
        check_out("ts_sat", 1, mkrec(16'hFFFF, 4'h0, 32'h5A5A0000), 4'd1, 1, 16'd2);
        idle(2, 0);
        drive(1, 1, 32'h5A5A0001, 4'h0, 0, 0);
        chk("ts_after_sat.fill", 64'(fill_level), 64'd2);
        idle(1, 1);
        chk("ts_after_sat.data", 64'(rec_data), 64'(mkrec(16'd3, 4'h0, 32'h5A5A0001)));
        idle(1, 1);
        chk("ts_after_sat.empty", 64'(rec_valid), 64'd0);

        // Build up five drops, then clear together with a capture and a pop.
        for (int i = 0; i < 11; i++) drive(1, 1, 32'h3000 + i, 4'h0, 0, 0);
        chk("pre_clear.fill", 64'(fill_level), 64'd8);
        chk("pre_clear.overflow", 64'(overflow), 64'd1);
        chk("pre_clear.drops", 64'(drop_count), 64'd5);
        drive(1, 1, 32'h00000BAD, 4'h0, 1, 1);
        check_out("clear", 0, 52'h0, 4'd0, 0, 16'd0);
        drive(1, 1, 32'h00000077, 4'h0, 0, 0);
        check_out("post_clear_ts", 1, mkrec(16'd0, 4'h0, 32'h77), 4'd1, 0, 16'd0);

        // Refill past full, start draining, then assert reset between clock edges.
        for (int i = 0; i < 8; i++) drive(1, 1, 32'h4000 + i, 4'h0, 0, 0);
        chk("pre_reset.fill", 64'(fill_level), 64'd8);
        chk("pre_reset.drops", 64'(drop_count), 64'd1);
        idle(1, 1);
        chk("pre_reset.drain", 64'(fill_level), 64'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 0, 52'h0, 4'd0, 0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
